// File: rtl/jpeg_blk_seq.sv
// Block-level sequencer for the quantizer -> RLC -> huffman JPEG pipeline.
// Admits one 8x8 block at a time into the quantizer, tracks occupancy of the
// two SRAM ping-pong banks between the RLC writer and the huffman reader,
// issues per-block huffman starts and flags end of frame.
//
// Ports:
//   clk, srst_n            clock, asynchronous active-low reset
//   start, mode_in         frame start pulse (IDLE only), quant table select
//   in_valid, in_ready     upstream block handshake (in_ready combinational)
//   q_enable, q_mode       one-cycle quantizer enable, latched table select
//   rlc_done, wr_bank      RLC block-written pulse, bank RLC writes next
//   huf_start, rd_bank     one-cycle huffman start, bank huffman reads
//   huf_done               huffman finished current block
//   busy, frame_done       not IDLE, one-cycle end-of-frame pulse
//   blk_cnt                blocks released this frame
//   err                    sticky protocol error, cleared on accepted start
module jpeg_blk_seq #(
    parameter int unsigned BLK_PER_FRAME = 64,
    parameter int unsigned CNT_W         = 10
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             start,
    input  logic             mode_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             q_enable,
    output logic             q_mode,
    input  logic             rlc_done,
    output logic             wr_bank,
    output logic             huf_start,
    output logic             rd_bank,
    input  logic             huf_done,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLK_PER_FRAME);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       occ, occ_nxt;
    logic             inflight, inflight_nxt;
    logic             huf_busy, huf_busy_nxt;
    logic [CNT_W-1:0] issued, issued_nxt;
    logic [CNT_W-1:0] released, released_nxt;
    logic             q_enable_nxt, q_mode_nxt;
    logic             wr_bank_nxt, rd_bank_nxt;
    logic             huf_start_nxt, frame_done_nxt, err_nxt;
    logic             handshake, rlc_ok, huf_ok;

    // Only one block may be in the quantizer/RLC at a time, and only while a
    // bank is free to receive it.
    assign in_ready  = (state == RUN) && !inflight && (occ < 2'd2) && (issued < LAST_BLK);
    assign handshake = in_valid && in_ready;
    assign rlc_ok    = (state == RUN) && rlc_done && inflight;
    assign huf_ok    = (state == RUN) && huf_done && huf_busy;

    assign busy    = (state != IDLE);
    assign blk_cnt = released;

    // State and datapath registers.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state      <= IDLE;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            huf_busy   <= 1'b0;
            issued     <= '0;
            released   <= '0;
            q_enable   <= 1'b0;
            q_mode     <= 1'b0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            huf_start  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            occ        <= occ_nxt;
            inflight   <= inflight_nxt;
            huf_busy   <= huf_busy_nxt;
            issued     <= issued_nxt;
            released   <= released_nxt;
            q_enable   <= q_enable_nxt;
            q_mode     <= q_mode_nxt;
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            huf_start  <= huf_start_nxt;
            frame_done <= frame_done_nxt;
            err        <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        occ_nxt        = occ;
        inflight_nxt   = inflight;
        huf_busy_nxt   = huf_busy;
        issued_nxt     = issued;
        released_nxt   = released;
        q_enable_nxt   = 1'b0;
        q_mode_nxt     = q_mode;
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        huf_start_nxt  = 1'b0;
        frame_done_nxt = 1'b0;
        err_nxt        = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = RUN;
                    q_mode_nxt   = mode_in;
                    occ_nxt      = 2'd0;
                    inflight_nxt = 1'b0;
                    huf_busy_nxt = 1'b0;
                    issued_nxt   = '0;
                    released_nxt = '0;
                    wr_bank_nxt  = 1'b0;
                    rd_bank_nxt  = 1'b0;
                    err_nxt      = 1'b0;
                end
                // Completion events with no frame running are protocol errors.
                if (rlc_done || huf_done) begin
                    err_nxt = 1'b1;
                end
            end

            RUN: begin
                if (handshake) begin
                    q_enable_nxt = 1'b1;
                    inflight_nxt = 1'b1;
                    issued_nxt   = issued + CNT_ONE;
                end

                if (rlc_done) begin
                    if (inflight) begin
                        inflight_nxt = 1'b0;
                        wr_bank_nxt  = ~wr_bank;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end

                if (huf_done) begin
                    if (huf_busy) begin
                        huf_busy_nxt = 1'b0;
                        rd_bank_nxt  = ~rd_bank;
                        released_nxt = released + CNT_ONE;
                        if (released_nxt == LAST_BLK) begin
                            frame_done_nxt = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end

                // Simultaneous write and release leave occupancy unchanged.
                unique case ({rlc_ok, huf_ok})
                    2'b10:   occ_nxt = occ + 2'd1;
                    2'b01:   occ_nxt = occ - 2'd1;
                    default: occ_nxt = occ;
                endcase

                // Dispatch looks at registered occ/huf_busy, so a release is
                // reflected before the next block is started.
                if ((occ != 2'd0) && !huf_busy && !huf_start) begin
                    huf_start_nxt = 1'b1;
                    huf_busy_nxt  = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jpeg_blk_seq.sv
// Directed bench for jpeg_blk_seq with a bank scoreboard: every accepted RLC
// write pushes the bank it landed in, every huf_start pops and must read it.
module tb_jpeg_blk_seq;

    localparam int unsigned BLK = 4;
    localparam int unsigned CW  = 10;

    logic          clk;
    logic          srst_n;
    logic          start;
    logic          mode_in;
    logic          in_valid;
    logic          in_ready;
    logic          q_enable;
    logic          q_mode;
    logic          rlc_done;
    logic          wr_bank;
    logic          huf_start;
    logic          rd_bank;
    logic          huf_done;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] blk_cnt;
    logic          err;

    int checks = 0;
    int errors = 0;
    int qe_cnt = 0;
    int hs_cnt = 0;
    logic sb_q[$];
    logic m_wr;

    logic [8:0] outs;
    assign outs = {q_enable, q_mode, wr_bank, huf_start, rd_bank, busy, frame_done, err, in_ready};

    jpeg_blk_seq #(
        .BLK_PER_FRAME(BLK),
        .CNT_W        (CW)
    ) dut (
        .clk       (clk),
        .srst_n    (srst_n),
        .start     (start),
        .mode_in   (mode_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_enable  (q_enable),
        .q_mode    (q_mode),
        .rlc_done  (rlc_done),
        .wr_bank   (wr_bank),
        .huf_start (huf_start),
        .rd_bank   (rd_bank),
        .huf_done  (huf_done),
        .busy      (busy),
        .frame_done(frame_done),
        .blk_cnt   (blk_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse counting and bank scoreboard, sampled on the inactive edge.
    always @(negedge clk) begin
        if (srst_n) begin
            if (q_enable) qe_cnt++;
            if (huf_start) begin
                hs_cnt++;
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    logic exp_bank;
                    exp_bank = sb_q.pop_front();
                    check("sb_rd_bank", 32'(rd_bank), 32'(exp_bank));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            case (which)
                0:       seen = q_enable;
                1:       seen = huf_start;
                default: seen = frame_done;
            endcase
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_start(input logic mode);
        mode_in = mode;
        start   = 1'b1;
        sb_q.delete();
        m_wr    = 1'b0;
        cyc();
        start   = 1'b0;
    endtask

    // One-cycle rlc_done; a real block is recorded in the scoreboard.
    task automatic drive_rlc(input bit real_blk);
        rlc_done = 1'b1;
        if (real_blk) begin
            sb_q.push_back(m_wr);
            m_wr = ~m_wr;
        end
        cyc();
        rlc_done = 1'b0;
    endtask

    task automatic drive_huf();
        huf_done = 1'b1;
        cyc();
        huf_done = 1'b0;
    endtask

    // Full frame with RLC answering 10 cycles after q_enable and huffman
    // answering 5 cycles after huf_start.
    task automatic run_frame(input logic mode, input string tag);
        int rlc_t = 0;
        int hf_t  = 0;
        int hd    = 0;
        int qe0;
        int hs0;
        bit done  = 1'b0;
        qe0 = qe_cnt;
        hs0 = hs_cnt;
        do_start(mode);
        check({tag, "_q_mode"}, 32'(q_mode), 32'(mode));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        check({tag, "_blk_cnt_clr"}, 32'(blk_cnt), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (frame_done) begin
                done = 1'b1;
                check({tag, "_huf_done_at_fd"}, 32'(hd), 32'(BLK));
            end else begin
                rlc_done = 1'b0;
                huf_done = 1'b0;
                if (rlc_t > 0) begin
                    rlc_t--;
                    if (rlc_t == 0) begin
                        rlc_done = 1'b1;
                        sb_q.push_back(m_wr);
                        m_wr = ~m_wr;
                    end
                end
                if (hf_t > 0) begin
                    hf_t--;
                    if (hf_t == 0) begin
                        huf_done = 1'b1;
                        hd++;
                    end
                end
                if (q_enable) rlc_t = 10;
                if (huf_start) hf_t = 5;
                cyc();
            end
        end
        rlc_done = 1'b0;
        huf_done = 1'b0;
        in_valid = 1'b0;
        check({tag, "_frame_done_seen"}, 32'(done), 32'd1);
        check({tag, "_blk_cnt"}, 32'(blk_cnt), 32'(BLK));
        cyc();
        check({tag, "_q_enables"}, 32'(qe_cnt - qe0), 32'(BLK));
        check({tag, "_huf_starts"}, 32'(hs_cnt - hs0), 32'(BLK));
        check({tag, "_blk_cnt_hold"}, 32'(blk_cnt), 32'(BLK));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_fd_pulse"}, 32'(frame_done), 32'd0);
        check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int qe_snap;
        srst_n   = 1'b0;
        start    = 1'b0;
        mode_in  = 1'b0;
        in_valid = 1'b0;
        rlc_done = 1'b0;
        huf_done = 1'b0;
        m_wr     = 1'b0;
        #23;
        check("reset_outs", 32'(outs), 32'd0);
        check("reset_blk_cnt", 32'(blk_cnt), 32'd0);
        srst_n = 1'b1;
        cyc();
        check("idle_outs", 32'(outs), 32'd0);

        // Nominal frame with mode 1.
        run_frame(1'b1, "t1");

        // Backpressure: huffman withheld while both banks fill.
        do_start(1'b0);
        check("t2_q_mode", 32'(q_mode), 32'd0);
        in_valid = 1'b1;
        wait_sig(0, 20, "t2_qe1");
        drive_rlc(1'b1);
        wait_sig(0, 20, "t2_qe2");
        drive_rlc(1'b1);
        cyc();
        cyc();
        qe_snap = qe_cnt;
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        repeat (5) cyc();
        check("t2_no_3rd_qe", 32'(qe_cnt - qe_snap), 32'd0);
        check("t2_in_ready_still_full", 32'(in_ready), 32'd0);
        drive_huf();
        check("t2_in_ready_back", 32'(in_ready), 32'd1);
        check("t2_blk_cnt", 32'(blk_cnt), 32'd1);
        cyc();
        check("t3_pre_hs", 32'(huf_start), 32'd1);
        check("t3_pre_qe", 32'(q_enable), 32'd1);
        check("t3_pre_wr", 32'(wr_bank), 32'(m_wr));
        check("t3_pre_rd", 32'(rd_bank), 32'd1);

        // Simultaneous rlc_done and huf_done with occ=1.
        rlc_done = 1'b1;
        huf_done = 1'b1;
        sb_q.push_back(m_wr);
        m_wr = ~m_wr;
        cyc();
        rlc_done = 1'b0;
        huf_done = 1'b0;
        check("t3_wr_toggle", 32'(wr_bank), 32'(m_wr));
        check("t3_rd_toggle", 32'(rd_bank), 32'd0);
        check("t3_occ_kept", 32'(in_ready), 32'd1);
        check("t3_blk_cnt", 32'(blk_cnt), 32'd2);
        check("t3_hs_gap", 32'(huf_start), 32'd0);
        cyc();
        check("t3_hs_next", 32'(huf_start), 32'd1);
        check("t3_qe4", 32'(q_enable), 32'd1);
        in_valid = 1'b0;
        drive_rlc(1'b1);
        drive_huf();
        check("t3_blk_cnt3", 32'(blk_cnt), 32'd3);
        wait_sig(1, 20, "t3_hs4");
        drive_huf();
        check("t3_frame_done", 32'(frame_done), 32'd1);
        check("t3_blk_cnt4", 32'(blk_cnt), 32'd4);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_err", 32'(err), 32'd0);
        cyc();

        // Start during RUN is ignored; spurious completions set err.
        do_start(1'b1);
        in_valid = 1'b1;
        wait_sig(0, 20, "t5_qe1");
        in_valid = 1'b0;
        drive_rlc(1'b1);
        wait_sig(1, 20, "t5_hs1");
        drive_huf();
        check("t5_blk_cnt1", 32'(blk_cnt), 32'd1);
        cyc();
        mode_in = 1'b0;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        check("t5_q_mode_kept", 32'(q_mode), 32'd1);
        check("t5_blk_cnt_kept", 32'(blk_cnt), 32'd1);
        check("t5_no_err", 32'(err), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        drive_rlc(1'b0);
        check("t4_err_rlc", 32'(err), 32'd1);
        check("t4_wr_kept", 32'(wr_bank), 32'(m_wr));
        check("t4_blk_cnt_kept", 32'(blk_cnt), 32'd1);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        drive_huf();
        check("t4_err_sticky", 32'(err), 32'd1);
        check("t4_rd_kept", 32'(rd_bank), 32'd1);
        check("t4_blk_cnt_kept2", 32'(blk_cnt), 32'd1);

        // Asynchronous reset with issued=2 while q_enable is high.
        in_valid = 1'b1;
        wait_sig(0, 20, "t6_qe2");
        in_valid = 1'b0;
        srst_n = 1'b0;
        #1;
        check("t6_async_outs", 32'(outs), 32'd0);
        check("t6_async_blk_cnt", 32'(blk_cnt), 32'd0);
        sb_q.delete();
        m_wr = 1'b0;
        cyc();
        cyc();
        srst_n = 1'b1;
        cyc();
        check("t6_post_outs", 32'(outs), 32'd0);

        // Spurious events in IDLE, then start clears err.
        drive_huf();
        check("t4_idle_err", 32'(err), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_blk_cnt", 32'(blk_cnt), 32'd0);
        drive_rlc(1'b0);
        check("t4_idle_wr", 32'(wr_bank), 32'd0);
        run_frame(1'b0, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard against a stuck run.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jpeg_blk_seq.md
Name: jpeg_blk_seq

Overview:
- Block-level sequencer for the quantizer -> RLC -> huffman JPEG pipeline.
- Admits one 8x8 DCT block at a time into the quantizer and tracks the two SRAM ping-pong banks between the RLC writer and the huffman reader.
- Issues per-block huffman starts and signals end of frame.
- Sits at top level between the DCT source and the existing datapath enable/valid signals.

Parameters:
- BLK_PER_FRAME, 64, blocks per frame (1..1023).
- CNT_W, 10, width of the block counters; must satisfy 2^CNT_W > BLK_PER_FRAME.

Ports:
- clk  in  1  clock
- srst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; accepted only in IDLE
- mode_in  in  1  quantization table select; latched on accepted start
- in_valid  in  1  upstream DCT block present on dct inputs
- in_ready  out  1  block may be accepted this cycle
- q_enable  out  1  one-cycle enable pulse to quantizer
- q_mode  out  1  latched mode to quantizer
- rlc_done  in  1  RLC vaild pulse; block fully written to SRAM
- wr_bank  out  1  bank the RLC writes next (SRAM waddr MSB)
- huf_start  out  1  one-cycle pulse; huffman begins reading rd bank
- rd_bank  out  1  bank the huffman reads (SRAM raddr MSB)
- huf_done  in  1  huffman finished current block
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after last block is released
- blk_cnt  out  CNT_W  blocks fully released this frame
- err  out  1  sticky protocol error; cleared on accepted start

Behaviour:
States: IDLE, RUN.

Reset values:
- All outputs 0; state IDLE.
- Internal state 0: occ (0..2), inflight, huf_busy, issued, released.

Frame start:
- IDLE with start=1: next edge -> RUN.
- Same edge: q_mode <= mode_in; counters, occ, wr_bank, rd_bank and err cleared.
- start in RUN is ignored and does not set err.

Input acceptance:
- in_ready (combinational) = RUN && !inflight && occ<2 && issued<BLK_PER_FRAME.
- A handshake is in_valid && in_ready.
- On handshake, at the next edge: q_enable=1 for exactly one cycle, inflight<=1, issued++.
- in_ready is therefore low in the cycle q_enable is high.

RLC completion:
- rlc_done with inflight=1: inflight<=0, occ++, wr_bank toggles.
- rlc_done with inflight=0: ignored, err<=1.

Huffman dispatch:
- If RUN && occ>0 && !huf_busy && !huf_start, then at the next edge: huf_start=1 for one cycle, huf_busy<=1.
- rd_bank is stable from huf_start until huf_done.

Huffman completion:
- huf_done with huf_busy=1: huf_busy<=0, occ--, rd_bank toggles, released++.
- huf_done with huf_busy=0: ignored, err<=1.

Simultaneous events and ordering:
- rlc_done and huf_done in the same cycle: occ unchanged, both bank pointers toggle.
- occ never exceeds 2 or goes below 0.
- huf_done and a new dispatch in the same cycle: the dispatch uses the post-update occ and rd_bank, so earliest back-to-back huf_start is 2 cycles after huf_done.

Frame end:
- When released reaches BLK_PER_FRAME: frame_done=1 for one cycle on the same edge, state -> IDLE.
- blk_cnt holds its final value until the next accepted start.

Other rules:
- Events outside RUN (rlc_done, huf_done) set err; state is otherwise unchanged.
- Asynchronous reset mid-frame returns everything to reset values immediately; no partial frame resumes.
- Counters never wrap; issued saturates at BLK_PER_FRAME by the in_ready gating.

Test Plan:
1. Reset then start, mode_in=1, BLK_PER_FRAME=4; in_valid held 1; RLC done 10 cycles after each q_enable; huffman done 5 cycles after each huf_start. Required: q_mode=1; 4 q_enable pulses; 4 huf_start pulses with rd_bank 0,1,0,1; frame_done after the 4th huf_done; blk_cnt=4; err=0.
2. Backpressure: huf_done withheld. Required: after 2 rlc_done occ=2 and in_ready=0 with no 3rd q_enable; a single huf_done restores in_ready the next cycle.
3. rlc_done and huf_done in the same cycle with occ=1. Required: occ stays 1, wr_bank and rd_bank both toggle, a new huf_start follows 1 cycle later.
4. Spurious rlc_done with inflight=0 and spurious huf_done in IDLE. Required: err=1 sticky, counters unchanged; the next start clears err.
5. start pulsed during RUN. Required: ignored, no counter clear, q_mode unchanged.
6. srst_n asserted mid-frame (issued=2). Required: all outputs 0 asynchronously; after release, a new start runs a full frame correctly.
